operand_sequencer: RTL and testbench



---
 rtl/operand_sequencer.sv | 163 ++++++++++++++++
 tb/tb_operand_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// operand_sequencer: collects two little-endian operands byte-by-byte from the
// switch input on enter presses, kicks the ALU, waits for its done with a
// timeout, and presents the captured result as two selectable 16-bit halves.
module operand_sequencer #(
  parameter int unsigned NBYTES  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enter,
  input  logic                  loaddata,
  input  logic [7:0]            inputdata,
  input  logic                  alu_done,
  input  logic [31:0]           dataR,
  output logic [8*NBYTES-1:0]   dataA,
  output logic [8*NBYTES-1:0]   dataB,
  output logic                  alu_start,
  output logic                  inputdata_ready,
  output logic [15:0]           disp_value,
  output logic [1:0]            byte_sel,
  output logic [2:0]            phase,
  output logic                  err
);

  localparam int unsigned OP_W  = 8 * NBYTES;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0]       LAST_BYTE = 2'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  // Encoding doubles as the status LED code driven on phase.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_SHOW_LO = 3'd5,
    S_SHOW_HI = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  state_e           state_q;
  logic             enter_q;
  logic [1:0]       byte_sel_q;
  logic [OP_W-1:0]  data_a_q;
  logic [OP_W-1:0]  data_b_q;
  logic [31:0]      result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             enter_pulse;

  // Rising edge of the debounced button; enter_q resets high so a press held
  // through reset is not seen as a new press.
  assign enter_pulse = enter & ~enter_q;

  // Sequencer state, operand/result storage and ALU timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      enter_q    <= 1'b1;
      byte_sel_q <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
    end else begin
      enter_q <= enter;
      case (state_q)
        S_IDLE: begin
          if (loaddata) begin
            state_q    <= S_LOAD_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            byte_sel_q <= '0;
          end
        end
        S_LOAD_A: begin
          // Abort takes priority over a simultaneous press.
          if (!loaddata) begin
            state_q    <= S_IDLE;
            byte_sel_q <= '0;
          end else if (enter_pulse) begin
            data_a_q[{byte_sel_q, 3'b000} +: 8] <= inputdata;
            if (byte_sel_q == LAST_BYTE) begin
              byte_sel_q <= '0;
              state_q    <= S_LOAD_B;
            end else begin
              byte_sel_q <= byte_sel_q + 2'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (!loaddata) begin
            state_q    <= S_IDLE;
            byte_sel_q <= '0;
          end else if (enter_pulse) begin
            data_b_q[{byte_sel_q, 3'b000} +: 8] <= inputdata;
            if (byte_sel_q == LAST_BYTE) begin
              byte_sel_q <= '0;
              state_q    <= S_START;
            end else begin
              byte_sel_q <= byte_sel_q + 2'd1;
            end
          end
        end
        S_START: begin
          // alu_done is deliberately not looked at here.
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the final counted cycle still wins over the timeout.
          if (alu_done) begin
            result_q <= dataR;
            state_q  <= S_SHOW_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SHOW_LO, S_SHOW_HI: begin
          if (enter_pulse) begin
            if (loaddata) begin
              state_q    <= S_LOAD_A;
              data_a_q   <= '0;
              data_b_q   <= '0;
              byte_sel_q <= '0;
            end else begin
              state_q <= (state_q == S_SHOW_LO) ? S_SHOW_HI : S_SHOW_LO;
            end
          end
        end
        S_ERROR: begin
          if (enter_pulse) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Display value decoded from the registered state and captured result.
  always_comb begin
    disp_value = '0;
    case (state_q)
      S_SHOW_LO: disp_value = result_q[15:0];
      S_SHOW_HI: disp_value = result_q[31:16];
      S_ERROR:   disp_value = 16'hEEEE;
      default:   disp_value = '0;
    endcase
  end

  assign dataA           = data_a_q;
  assign dataB           = data_b_q;
  assign byte_sel        = byte_sel_q;
  assign phase           = state_q;
  assign alu_start       = (state_q == S_START);
  assign inputdata_ready = (state_q == S_SHOW_LO) || (state_q == S_SHOW_HI);
  assign err             = (state_q == S_ERROR);

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed plan items followed by randomized
// operations, with a queue of expected ALU-start/display events checked by a
// separate monitor.
module tb_operand_sequencer;

  localparam int T = 8;

  logic        clk;
  logic        reset;
  logic        enter;
  logic        loaddata;
  logic [7:0]  inputdata;
  logic        alu_done;
  logic [31:0] dataR;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        alu_start;
  logic        inputdata_ready;
  logic [15:0] disp_value;
  logic [1:0]  byte_sel;
  logic [2:0]  phase;
  logic        err;

  operand_sequencer #(.NBYTES(4), .TIMEOUT(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .enter          (enter),
    .loaddata       (loaddata),
    .inputdata      (inputdata),
    .alu_done       (alu_done),
    .dataR          (dataR),
    .dataA          (dataA),
    .dataB          (dataB),
    .alu_start      (alu_start),
    .inputdata_ready(inputdata_ready),
    .disp_value     (disp_value),
    .byte_sel       (byte_sel),
    .phase          (phase),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ph;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] disp;
    logic        rdy;
    logic        er;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t mk(input int ph, input int c, input logic [31:0] a,
                              input logic [31:0] b, input logic [15:0] d,
                              input logic r, input logic e);
    exp_t x;
    x.ph = ph; x.cyc = c; x.a = a; x.b = b; x.disp = d; x.rdy = r; x.er = e;
    return x;
  endfunction

  // Operand model: byte lists composed into a value with plain arithmetic.
  logic [7:0] ba [4];
  logic [7:0] bb [4];
  logic [7:0] byte_src[$];

  function automatic logic [31:0] pack(input logic [7:0] b [4]);
    logic [31:0] v;
    v = 32'(b[0]) + (32'(b[1]) << 8) + (32'(b[2]) << 16) + (32'(b[3]) << 24);
    return v;
  endfunction

  // ALU responder: raises alu_done for the posedges the driver scheduled.
  int done_cyc = -10;
  int ign_cyc  = -10;
  initial begin
    alu_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      alu_done = (cyc + 1 == done_cyc) || (cyc + 1 == ign_cyc);
    end
  end

  // Monitor: each entry into START/SHOW/ERROR must match the next expectation.
  logic [2:0] prev_phase = 3'd0;
  bit         chk_start_low = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_start_low) begin
        chk("alu_start_one_cycle", 32'(alu_start), 32'd0);
        chk_start_low = 1'b0;
      end
      if (!reset && phase != prev_phase &&
          (phase == 3'd3 || phase == 3'd5 || phase == 3'd6 || phase == 3'd7)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: phase %0d at cycle %0d, nothing expected", phase, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_phase", 32'(phase), 32'(e.ph));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          chk("event_disp", 32'(disp_value), 32'(e.disp));
          chk("event_ready", 32'(inputdata_ready), 32'(e.rdy));
          chk("event_err", 32'(err), 32'(e.er));
          if (e.ph == 3) begin
            chk("start_dataA", dataA, e.a);
            chk("start_dataB", dataB, e.b);
            chk("start_pulse", 32'(alu_start), 32'd1);
            chk_start_low = 1'b1;
          end
        end
      end
      prev_phase = phase;
    end
  end

  task automatic press(input logic [7:0] d, input int hold);
    inputdata = d;
    enter     = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] next_byte();
    logic [7:0] d;
    if (byte_src.size() != 0) d = byte_src.pop_front();
    else d = 8'($urandom);
    return d;
  endfunction

  // Enters bytes 0..6 (A0..A3, B0..B2); optionally aborts before byte abort_at.
  task automatic enter_bytes(input int abort_at, input int hold0, output bit aborted);
    logic [7:0] d;
    int         h;
    aborted = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == abort_at) begin
        loaddata  = 1'b0;
        inputdata = 8'($urandom);
        enter     = 1'($urandom_range(0, 1));
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        chk("abort_phase", 32'(phase), 32'd0);
        chk("abort_bsel", 32'(byte_sel), 32'd0);
        chk("abort_keepA", dataA, pack(ba));
        chk("abort_keepB", dataB, pack(bb));
        aborted = 1'b1;
        return;
      end
      d = next_byte();
      h = (i == 0 && hold0 > 0) ? hold0 : int'($urandom_range(1, 3));
      press(d, h);
      if (i < 4) ba[i] = d;
      else bb[i-4] = d;
      chk("load_bsel", 32'(byte_sel), 32'((i + 1) % 4));
      chk("load_phase", 32'(phase), (i < 3) ? 32'd1 : 32'd2);
      chk("load_dataA", dataA, pack(ba));
      chk("load_dataB", dataB, pack(bb));
      chk("load_ready", 32'(inputdata_ready), 32'd0);
    end
  endtask

  // One operation starting from a cleared LOAD_A; ends back in a cleared LOAD_A.
  // k: WAIT sample (1-based) at which done is seen; 0 = never.
  task automatic run_op(input int abort_at, input int hold0, input int k,
                        input logic [31:0] r, input int ntog, input bit ign);
    bit         ab;
    logic [7:0] d;
    int         n, o, c;
    bit         hi;
    bit         ok;
    ba = '{default: 8'h00};
    bb = '{default: 8'h00};
    enter_bytes(abort_at, hold0, ab);
    if (ab) begin
      loaddata = 1'b1;
      @(negedge clk);
      chk("restart_phase", 32'(phase), 32'd1);
      chk("restart_bsel", 32'(byte_sel), 32'd0);
      ba = '{default: 8'h00};
      bb = '{default: 8'h00};
      enter_bytes(-1, 0, ab);
    end
    d     = next_byte();
    bb[3] = d;
    dataR = r;
    n     = cyc + 1;
    ok    = (k >= 1 && k <= T);
    done_cyc = (k >= 1) ? n + 1 + k : -10;
    ign_cyc  = ign ? n + 1 : -10;
    exp_q.push_back(mk(3, n, pack(ba), pack(bb), 16'h0000, 1'b0, 1'b0));
    if (ok) begin
      o = n + 1 + k;
      exp_q.push_back(mk(5, o, 32'd0, 32'd0, r[15:0], 1'b1, 1'b0));
    end else begin
      o = n + 1 + T;
      exp_q.push_back(mk(7, o, 32'd0, 32'd0, 16'hEEEE, 1'b0, 1'b1));
    end
    inputdata = d;
    enter     = 1'b1;
    @(negedge clk);
    enter    = 1'b0;
    loaddata = 1'b0;
    while (cyc < o) @(negedge clk);
    if (ok) begin
      hi = 1'b0;
      for (int t = 0; t < ntog; t++) begin
        c  = cyc;
        hi = ~hi;
        exp_q.push_back(mk(hi ? 6 : 5, c + 1, 32'd0, 32'd0,
                           hi ? r[31:16] : r[15:0], 1'b1, 1'b0));
        press(8'($urandom), int'($urandom_range(1, 3)));
      end
      loaddata = 1'b1;
      press(8'($urandom), 1);
      chk("newop_phase", 32'(phase), 32'd1);
      chk("newop_bsel", 32'(byte_sel), 32'd0);
      chk("newop_dataA", dataA, 32'd0);
      chk("newop_dataB", dataB, 32'd0);
      chk("newop_ready", 32'(inputdata_ready), 32'd0);
    end else begin
      press(8'($urandom), 1);
      chk("err_clear_phase", 32'(phase), 32'd0);
      chk("err_clear_err", 32'(err), 32'd0);
      chk("err_clear_disp", 32'(disp_value), 32'd0);
      loaddata = 1'b1;
      @(negedge clk);
      chk("idle_to_load", 32'(phase), 32'd1);
    end
  endtask

  initial begin
    int ab_at;
    reset     = 1'b1;
    enter     = 1'b1;
    loaddata  = 1'b0;
    inputdata = 8'h00;
    dataR     = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_dataA", dataA, 32'd0);
    chk("rst_dataB", dataB, 32'd0);
    chk("rst_start", 32'(alu_start), 32'd0);
    chk("rst_ready", 32'(inputdata_ready), 32'd0);
    chk("rst_disp", 32'(disp_value), 32'd0);
    chk("rst_bsel", 32'(byte_sel), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    // Button still held from reset: entering LOAD_A must not write a byte.
    loaddata  = 1'b1;
    inputdata = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    chk("held_phase", 32'(phase), 32'd1);
    chk("held_bsel", 32'(byte_sel), 32'd0);
    chk("held_dataA", dataA, 32'd0);
    enter = 1'b0;
    @(negedge clk);

    // Directed operation: known operands, 20-cycle held first press, two toggles.
    byte_src = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_op(-1, 20, 5, 32'hCAFEF00D, 2, 1'b0);
    // Abort after two bytes of A, then a clean restart.
    run_op(2, 0, 3, $urandom, 1, 1'b1);
    // ALU never answers.
    run_op(-1, 0, 0, $urandom, 0, 1'b0);
    // Done in the last counted WAIT cycle, with a stray done during START.
    run_op(-1, 0, T, $urandom, 3, 1'b1);
    // Done one cycle too late.
    run_op(-1, 0, T + 1, $urandom, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_op(ab_at, 0, int'($urandom_range(0, T + 2)), $urandom,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
